// File: rtl/pixel_tx_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_tx_framer_pkg
// Purpose  : Shared header bytes, FSM encoding and byte helpers for the framer.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_tx_framer_pkg;

    localparam logic [7:0] c_HDR_SOF = 8'h50;
    localparam logic [7:0] c_HDR_SOR = 8'h51;
    localparam logic [7:0] c_HDR_EOF = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SOF     = 3'd1,
        ST_SOR     = 3'd2,
        ST_PIX_MSB = 3'd3,
        ST_PIX_LSB = 3'd4,
        ST_PAD_MSB = 3'd5,
        ST_PAD_LSB = 3'd6,
        ST_EOF     = 3'd7
    } state_t;

    function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_tx_framer_pixel_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_buffer
// Purpose  : Single-clock 16-bit FIFO with full/empty flags and flush.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_buffer #(
    parameter int PIX_BUF_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        full,
    output logic        empty
);
    localparam logic [PIX_BUF_AW:0] c_FULL = {1'b1, {PIX_BUF_AW{1'b0}}};

    logic [15:0]           r_mem [1 << PIX_BUF_AW];
    logic [PIX_BUF_AW-1:0] r_wr_ptr;
    logic [PIX_BUF_AW-1:0] r_rd_ptr;
    logic [PIX_BUF_AW:0]   r_count;
    logic                  w_pop_ok;
    logic                  w_push_ok;

    // A pop in the same cycle frees the slot, so a push on full still lands
    assign w_pop_ok  = pop && (r_count != '0);
    assign w_push_ok = push && ((r_count != c_FULL) || w_pop_ok);
    assign rdata     = r_mem[r_rd_ptr];
    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
            else if (w_pop_ok && !w_push_ok) r_count <= r_count - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_tx_framer
// Purpose  : Packs CCD pixel samples into SOF/SOR/pixel/EOF byte packets.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_tx_framer
    import pixel_tx_framer_pkg::*;
#(
    parameter int         PIX_BUF_AW = 4,
    parameter logic [7:0] HDR_SOF    = c_HDR_SOF,
    parameter logic [7:0] HDR_SOR    = c_HDR_SOR,
    parameter logic [7:0] HDR_EOF    = c_HDR_EOF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [15:0] frame_rows,
    input  logic [15:0] frame_cols,
    input  logic        frame_end,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic [7:0]  tx_wdata,
    output logic        tx_winc,
    input  logic        tx_wfull,
    output logic        busy,
    output logic [7:0]  drop_count
);
    state_t      r_state, w_state_nxt;
    logic [2:0]  r_bidx;
    logic        r_arm, r_busy, r_fe_seen;
    logic [15:0] r_rows, r_cols, r_row, r_col;
    logic [7:0]  r_csum, r_drop;
    logic        w_emit, w_wr, w_start, w_pop, w_flush, w_pix_done;
    logic [7:0]  w_byte;
    logic        w_push, w_drop, w_buf_full, w_buf_empty;
    logic [15:0] w_buf_rdata;

    // Once the EOF trailer starts, further samples belong to no frame
    assign w_push = pix_valid && r_busy && (r_state != ST_EOF);
    assign w_drop = w_push && w_buf_full && !w_pop;

    pixel_buffer #(.PIX_BUF_AW(PIX_BUF_AW)) u_pixel_buffer (
        .clk   (clk),
        .rst   (rst),
        .flush (w_flush),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (pix_data),
        .rdata (w_buf_rdata),
        .full  (w_buf_full),
        .empty (w_buf_empty)
    );

    assign w_wr       = w_emit && !tx_wfull;
    assign tx_winc    = w_wr;
    assign tx_wdata   = w_wr ? w_byte : 8'h00;
    assign busy       = r_busy;
    assign drop_count = r_drop;

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_byte      = 8'h00;
        w_start     = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_pix_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SOF;
                end
            end
            ST_SOF: begin
                // r_arm holds off the first header byte for one cycle after start
                w_emit = !r_arm;
                case (r_bidx)
                    3'd0:    w_byte = HDR_SOF;
                    3'd1:    w_byte = byte_sel(r_rows, 1'b1);
                    3'd2:    w_byte = byte_sel(r_rows, 1'b0);
                    3'd3:    w_byte = byte_sel(r_cols, 1'b1);
                    default: w_byte = byte_sel(r_cols, 1'b0);
                endcase
                if (w_emit && !tx_wfull && (r_bidx == 3'd4)) w_state_nxt = ST_SOR;
            end
            ST_SOR: begin
                w_emit = 1'b1;
                case (r_bidx)
                    3'd0:    w_byte = HDR_SOR;
                    3'd1:    w_byte = byte_sel(r_row, 1'b1);
                    default: w_byte = byte_sel(r_row, 1'b0);
                endcase
                if (!tx_wfull && (r_bidx == 3'd2)) w_state_nxt = ST_PIX_MSB;
            end
            ST_PIX_MSB: begin
                if (!w_buf_empty) begin
                    w_emit = 1'b1;
                    w_byte = byte_sel(w_buf_rdata, 1'b1);
                    if (!tx_wfull) w_state_nxt = ST_PIX_LSB;
                end else if (r_fe_seen) begin
                    w_state_nxt = ST_PAD_MSB;
                end
            end
            ST_PIX_LSB: begin
                w_emit = 1'b1;
                w_byte = byte_sel(w_buf_rdata, 1'b0);
                if (!tx_wfull) begin
                    w_pop      = 1'b1;
                    w_pix_done = 1'b1;
                end
            end
            ST_PAD_MSB: begin
                w_emit = 1'b1;
                if (!tx_wfull) w_state_nxt = ST_PAD_LSB;
            end
            ST_PAD_LSB: begin
                w_emit = 1'b1;
                if (!tx_wfull) w_pix_done = 1'b1;
            end
            ST_EOF: begin
                w_emit = 1'b1;
                case (r_bidx)
                    3'd0:    w_byte = HDR_EOF;
                    3'd1:    w_byte = r_csum;
                    default: w_byte = r_drop;
                endcase
                if (!tx_wfull && (r_bidx == 3'd2)) begin
                    w_state_nxt = ST_IDLE;
                    w_flush     = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_pix_done) begin
            if (r_col == r_cols - 16'd1) begin
                w_state_nxt = (r_row == r_rows - 16'd1) ? ST_EOF : ST_SOR;
            end else begin
                w_state_nxt = ST_PIX_MSB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bidx    <= 3'd0;
            r_arm     <= 1'b0;
            r_busy    <= 1'b0;
            r_fe_seen <= 1'b0;
            r_rows    <= 16'd0;
            r_cols    <= 16'd0;
            r_row     <= 16'd0;
            r_col     <= 16'd0;
            r_csum    <= 8'h00;
            r_drop    <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_arm   <= w_start;
            if (w_state_nxt != r_state) r_bidx <= 3'd0;
            else if (w_wr)              r_bidx <= r_bidx + 3'd1;
            if (w_start) begin
                r_rows    <= frame_rows;
                r_cols    <= frame_cols;
                r_row     <= 16'd0;
                r_col     <= 16'd0;
                r_csum    <= 8'h00;
                r_drop    <= 8'h00;
                r_busy    <= 1'b1;
                r_fe_seen <= 1'b0;
            end else if (frame_end) begin
                r_fe_seen <= 1'b1;
            end
            if (w_wr && (r_state inside {ST_PIX_MSB, ST_PIX_LSB, ST_PAD_MSB, ST_PAD_LSB})) begin
                r_csum <= r_csum ^ w_byte;
            end
            if (w_pix_done) begin
                if (r_col == r_cols - 16'd1) begin
                    r_col <= 16'd0;
                    if (r_row != r_rows - 16'd1) r_row <= r_row + 16'd1;
                end else begin
                    r_col <= r_col + 16'd1;
                end
            end
            if (w_flush) r_busy <= 1'b0;
            if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_tx_framer
// Purpose  : Self-checking bench for pixel_tx_framer against a packet model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_tx_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [15:0] frame_rows = 16'd0;
    logic [15:0] frame_cols = 16'd0;
    logic        frame_end = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = 16'd0;
    logic [7:0]  tx_wdata;
    logic        tx_winc;
    logic        tx_wfull = 1'b0;
    logic        busy;
    logic [7:0]  drop_count;

    int tests_run = 0;
    int fails     = 0;
    int bad_winc  = 0;
    int wf_mode   = 0;
    int wf_cnt    = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    pixel_tx_framer #(.PIX_BUF_AW(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_rows  (frame_rows),
        .frame_cols  (frame_cols),
        .frame_end   (frame_end),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .tx_wdata    (tx_wdata),
        .tx_winc     (tx_winc),
        .tx_wfull    (tx_wfull),
        .busy        (busy),
        .drop_count  (drop_count)
    );

    // Fifo-full pattern: 0 none, 1 random isolated stalls, 2 held, 3 toggle every 3
    always @(posedge clk) begin
        #1;
        case (wf_mode)
            1: tx_wfull = tx_wfull ? 1'b0 : ($urandom_range(0, 2) == 0);
            2: tx_wfull = 1'b1;
            3: begin
                wf_cnt = wf_cnt + 1;
                if (wf_cnt >= 3) begin
                    wf_cnt   = 0;
                    tx_wfull = !tx_wfull;
                end
            end
            default: tx_wfull = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (tx_winc === 1'b1) begin
            got.push_back(tx_wdata);
            if (tx_wfull !== 1'b0) bad_winc++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int rows, input int cols);
        frame_rows  = 16'(rows);
        frame_cols  = 16'(cols);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic push_pix(input logic [15:0] v);
        pix_data  = v;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int done = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                done = 1;
                break;
            end
        end
        tests_run++;
        if (done == 0) begin
            fails++;
            $display("FAIL %s_idle: busy still high after %0d cycles, required 0", name, maxc);
        end
        tick();
    endtask

    // Packet model: header, rows of (SOR + pixels, pads after the supplied ones), trailer
    function automatic void build_exp(input int rows, input int cols,
                                      input logic [15:0] pix[$], input int drops);
        logic [7:0] cs = 8'h00;
        logic [15:0] v;
        int idx = 0;
        exp_q.delete();
        exp_q.push_back(8'h50);
        exp_q.push_back(8'((rows >> 8) & 255)); exp_q.push_back(8'(rows & 255));
        exp_q.push_back(8'((cols >> 8) & 255)); exp_q.push_back(8'(cols & 255));
        for (int r = 0; r < rows; r++) begin
            exp_q.push_back(8'h51);
            exp_q.push_back(8'((r >> 8) & 255)); exp_q.push_back(8'(r & 255));
            for (int c = 0; c < cols; c++) begin
                v = (idx < pix.size()) ? pix[idx] : 16'h0000;
                idx++;
                exp_q.push_back(v[15:8]);
                exp_q.push_back(v[7:0]);
                cs = cs ^ v[15:8] ^ v[7:0];
            end
        end
        exp_q.push_back(8'h52);
        exp_q.push_back(cs);
        exp_q.push_back(8'((drops > 255) ? 255 : drops));
    endfunction

    function automatic int first_diff();
        int n;
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
        if (got.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [7:0] qbyte(input logic [7:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 8'hxx;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        tests_run += 4;
        if (tx_winc !== 1'b0)     begin fails++; $display("FAIL reset_winc: got %b, required 0", tx_winc); end
        if (tx_wdata !== 8'h00)   begin fails++; $display("FAIL reset_wdata: got %h, required 00", tx_wdata); end
        if (busy !== 1'b0)        begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (drop_count !== 8'h00) begin fails++; $display("FAIL reset_drop: got %h, required 00", drop_count); end
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] ref_b [22] = '{8'h50, 8'h00, 8'h02, 8'h00, 8'h02, 8'h51, 8'h00, 8'h00,
                                   8'h12, 8'h34, 8'h56, 8'h78, 8'h51, 8'h00, 8'h01,
                                   8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h52, 8'h00, 8'h00};
        int d;
        got.delete();
        wf_mode = 0;
        start_frame(2, 2);
        @(negedge clk);
        tests_run += 2;
        if (busy !== 1'b1)    begin fails++; $display("FAIL basic_busy_rise: got %b, required 1", busy); end
        if (tx_winc !== 1'b0) begin fails++; $display("FAIL basic_first_cycle_winc: got %b, required 0", tx_winc); end
        tick();
        @(negedge clk);
        tests_run++;
        if (tx_winc !== 1'b1 || tx_wdata !== 8'h50) begin
            fails++;
            $display("FAIL basic_sof_latency: got winc=%b data=%h, required winc=1 data=50", tx_winc, tx_wdata);
        end
        tick();
        push_pix(16'h1234); push_pix(16'h5678); push_pix(16'h9ABC); push_pix(16'hDEF0);
        end_frame();
        wait_idle("basic", 200);
        exp_q.delete();
        foreach (ref_b[i]) exp_q.push_back(ref_b[i]);
        d = first_diff();
        tests_run++;
        if (d >= 0) begin
            fails++;
            $display("FAIL basic_stream: byte %0d got %h required %h (got %0d bytes, required %0d)",
                     d, qbyte(got, d), qbyte(exp_q, d), got.size(), exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] pq[$] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        int d, bad0;
        got.delete();
        bad0 = bad_winc;
        wf_mode = 3;
        start_frame(2, 2);
        foreach (pq[i]) begin
            repeat (3) tick();
            push_pix(pq[i]);
        end
        end_frame();
        wait_idle("backpressure", 400);
        wf_mode = 0;
        build_exp(2, 2, pq, 0);
        d = first_diff();
        tests_run += 3;
        if (d >= 0) begin
            fails++;
            $display("FAIL bp_stream: byte %0d got %h required %h (got %0d bytes, required %0d)",
                     d, qbyte(got, d), qbyte(exp_q, d), got.size(), exp_q.size());
        end
        if (bad_winc != bad0) begin fails++; $display("FAIL bp_winc_while_full: got %0d writes, required 0", bad_winc - bad0); end
        if (drop_count !== 8'h00) begin fails++; $display("FAIL bp_drop: got %h, required 00", drop_count); end
    endtask

    task automatic test_overflow();
        logic [15:0] pq[$];
        logic [15:0] kept[$];
        int d;
        got.delete();
        wf_mode = 2;
        tick(); tick();
        start_frame(1, 10);
        for (int k = 0; k < 10; k++) begin
            pq.push_back(16'($urandom));
            pix_data  = pq[k];
            pix_valid = 1'b1;
            tick();
        end
        pix_valid = 1'b0;
        end_frame();
        @(negedge clk);
        tests_run++;
        if (got.size() != 0) begin fails++; $display("FAIL ovf_held_full: got %0d bytes, required 0", got.size()); end
        tick();
        wf_mode = 0;
        wait_idle("overflow", 200);
        for (int k = 0; k < 4; k++) kept.push_back(pq[k]);
        build_exp(1, 10, kept, 6);
        d = first_diff();
        tests_run += 2;
        if (d >= 0) begin
            fails++;
            $display("FAIL ovf_stream: byte %0d got %h required %h (got %0d bytes, required %0d)",
                     d, qbyte(got, d), qbyte(exp_q, d), got.size(), exp_q.size());
        end
        if (drop_count !== 8'd6) begin fails++; $display("FAIL ovf_drop: got %0d, required 6", drop_count); end
    endtask

    task automatic test_ignored();
        logic [15:0] pq[$] = '{16'hA5C3, 16'h0FF1};
        int d;
        got.delete();
        for (int k = 0; k < 3; k++) push_pix(16'hBEEF);
        @(negedge clk);
        tests_run += 3;
        if (drop_count !== 8'd6) begin fails++; $display("FAIL ign_drop_hold: got %0d, required 6", drop_count); end
        if (busy !== 1'b0)       begin fails++; $display("FAIL ign_idle_busy: got %b, required 0", busy); end
        if (got.size() != 0)     begin fails++; $display("FAIL ign_idle_bytes: got %0d bytes, required 0", got.size()); end
        tick();
        start_frame(1, 2);
        start_frame(5, 7);
        // third sample is excess and must be discarded with the buffer
        push_pix(pq[0]); push_pix(pq[1]); push_pix(16'h7777);
        end_frame();
        wait_idle("ignored", 200);
        build_exp(1, 2, pq, 0);
        d = first_diff();
        tests_run += 2;
        if (d >= 0) begin
            fails++;
            $display("FAIL ign_stream: byte %0d got %h required %h (got %0d bytes, required %0d)",
                     d, qbyte(got, d), qbyte(exp_q, d), got.size(), exp_q.size());
        end
        if (drop_count !== 8'h00) begin fails++; $display("FAIL ign_drop: got %h, required 00", drop_count); end
    endtask

    task automatic test_short();
        logic [15:0] pq[$];
        int d;
        got.delete();
        pq.push_back(16'($urandom)); pq.push_back(16'($urandom));
        start_frame(1, 4);
        push_pix(pq[0]);
        repeat (2) tick();
        push_pix(pq[1]);
        end_frame();
        wait_idle("short", 200);
        build_exp(1, 4, pq, 0);
        d = first_diff();
        tests_run++;
        if (d >= 0) begin
            fails++;
            $display("FAIL short_stream: byte %0d got %h required %h (got %0d bytes, required %0d)",
                     d, qbyte(got, d), qbyte(exp_q, d), got.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] pq[$] = '{16'hC0DE};
        int k = 0;
        int d;
        got.delete();
        start_frame(2, 3);
        for (int cyc = 0; cyc < 400; cyc++) begin
            pix_valid = ((cyc % 12) == 0) && (k < 6);
            if (pix_valid) begin
                pix_data = 16'(k * 16'h1111);
                k++;
            end
            tick();
            if (got.size() >= 18) break;
        end
        pix_valid = 1'b0;
        tests_run++;
        if (got.size() < 18) begin fails++; $display("FAIL rstmid_reach_row1: got %0d bytes, required >= 18", got.size()); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests_run += 2;
        if (tx_winc !== 1'b0) begin fails++; $display("FAIL rstmid_winc: got %b, required 0", tx_winc); end
        if (busy !== 1'b0)    begin fails++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
        got.delete();
        repeat (20) tick();
        tests_run++;
        if (got.size() != 0) begin fails++; $display("FAIL rstmid_no_eof: got %0d bytes, required 0", got.size()); end
        start_frame(1, 1);
        push_pix(pq[0]);
        wait_idle("rstmid", 200);
        build_exp(1, 1, pq, 0);
        d = first_diff();
        tests_run++;
        if (d >= 0) begin
            fails++;
            $display("FAIL rstmid_stream: byte %0d got %h required %h (got %0d bytes, required %0d)",
                     d, qbyte(got, d), qbyte(exp_q, d), got.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            logic [15:0] pq[$];
            int rows, cols, n, d, bad0;
            rows = $urandom_range(1, 3);
            cols = $urandom_range(1, 4);
            n    = $urandom_range(0, rows * cols);
            got.delete();
            bad0    = bad_winc;
            wf_mode = 1;
            start_frame(rows, cols);
            for (int k = 0; k < n; k++) begin
                pq.push_back(16'($urandom));
                repeat ($urandom_range(11, 15)) tick();
                push_pix(pq[k]);
            end
            end_frame();
            wait_idle("random", 600);
            wf_mode = 0;
            build_exp(rows, cols, pq, 0);
            d = first_diff();
            tests_run += 3;
            if (d >= 0) begin
                fails++;
                $display("FAIL rand%0d_stream (%0dx%0d, %0d px): byte %0d got %h required %h (got %0d bytes, required %0d)",
                         f, rows, cols, n, d, qbyte(got, d), qbyte(exp_q, d), got.size(), exp_q.size());
            end
            if (bad_winc != bad0) begin fails++; $display("FAIL rand%0d_winc_while_full: got %0d writes, required 0", f, bad_winc - bad0); end
            if (drop_count !== 8'h00) begin fails++; $display("FAIL rand%0d_drop: got %h, required 00", f, drop_count); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_ignored();
        test_short();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_tx_framer.md
Name: pixel_tx_framer

Overview:
- Transmit-direction counterpart to the host command parser: packs AD9826 pixel samples from the CCD readout path into framed byte packets for the tx fifo / FT245 link.
- Sits between ccd_readout sample output and the tx fifo write port, in the `clk` domain.
- Absorbs short backpressure with an internal pixel buffer.
- Reports dropped samples and pads short frames so host framing never desyncs.

Parameters:
- PIX_BUF_AW, 4, pixel buffer address width (depth 2^PIX_BUF_AW 16-bit words).
- HDR_SOF, 8'h50, start-of-frame header byte.
- HDR_SOR, 8'h51, start-of-row header byte.
- HDR_EOF, 8'h52, end-of-frame header byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- frame_start  in  1  one-cycle pulse; latches frame_rows/frame_cols.
- frame_rows  in  16  rows in frame, 1..65535.
- frame_cols  in  16  pixels per row, 1..65535.
- frame_end  in  1  one-cycle pulse from readout; no more pixels for this frame.
- pix_valid  in  1  pixel sample valid; no backpressure to source.
- pix_data  in  16  pixel sample.
- tx_wdata  out  8  byte to tx fifo.
- tx_winc  out  1  tx fifo write strobe.
- tx_wfull  in  1  tx fifo full, active high.
- busy  out  1  frame in progress (SOF accepted, EOF not yet written).
- drop_count  out  8  pixels dropped in current/last frame, saturating at 255.

Behaviour:
- Reset (synchronous, active high, `clk` rising edge): tx_winc=0, tx_wdata=0, busy=0, drop_count=0, buffer empty, state IDLE. Reset mid-frame abandons the frame; no EOF is emitted.
- Byte write rule: tx_winc=1 only when !tx_wfull. At most one byte per cycle. tx_wdata is valid in the same cycle as tx_winc. Byte order is msb first for every 16-bit field.
- Packet format:
  - SOF: HDR_SOF, rows_msb, rows_lsb, cols_msb, cols_lsb.
  - Per row r (0-based): HDR_SOR, r_msb, r_lsb, then cols pixels (2 bytes each).
  - After the last row: HDR_EOF, checksum, drop_count.
  - checksum = XOR of all pixel bytes emitted in the frame, pad bytes included.
- FSM states: IDLE, SOF(5 bytes), SOR(3 bytes), PIX_MSB, PIX_LSB, PAD_MSB, PAD_LSB, EOF(3 bytes).
- IDLE: frame_start latches rows/cols, clears drop_count, checksum and frame_end_seen, sets busy, goes to SOF. busy rises the cycle after frame_start.
- SOF -> SOR when its last byte is written.
- SOR -> PIX_MSB after 3 bytes.
- PIX_MSB:
  - Waits for buffer non-empty; pops on the PIX_LSB write.
  - If buffer empty and frame_end_seen, goes to PAD_MSB (pad value 16'h0000).
- After each pixel (real or pad), increment the column counter. When col == cols-1: if row == rows-1 go to EOF, else row++ and go to SOR.
- EOF: after 3 bytes -> IDLE, busy=0. drop_count holds until the next frame_start.
- Input side:
  - pix_valid while busy and buffer not full: push.
  - Buffer full: drop the sample and saturating-increment drop_count.
  - pix_valid while !busy: ignored, not counted.
- Excess pixels after rows*cols have been emitted are ignored; the buffer is flushed on the transition to IDLE.
- frame_start while busy: ignored.
- frame_end sets sticky frame_end_seen, cleared at frame_start.
- Simultaneous push and pop on a full buffer: pop first, so the push succeeds with no drop.
- Latency: first SOF byte appears on the second cycle after frame_start, given !tx_wfull.

Decomposition:
- HDR_SOF/HDR_SOR/HDR_EOF byte constants go in the shared controller.vh header alongside the command codes; the parameter defaults reference them.
- Sub-module: pixel_buffer, a synchronous single-clock 16-bit FIFO with full/empty flags, parameterised by PIX_BUF_AW.
- Row/column counters, checksum and FSM stay in pixel_tx_framer.

Test Plan:
- Basic frame: rows=2, cols=2, pixels 1234,5678,9ABC,DEF0, tx_wfull=0 -> bytes 50 00 02 00 02 51 00 00 12 34 56 78 51 00 01 9A BC DE F0 52 00 00, busy falls after the last byte.
- Backpressure: same frame with tx_wfull toggling every 3 cycles -> identical byte sequence, no tx_winc while tx_wfull=1, drop_count=0.
- Overflow: PIX_BUF_AW=2, tx_wfull held 1, 10 pixels pushed, then frame_end, then release (rows=1, cols=10) -> first 4 pixels emitted, 6 pads of 00 00, drop_count=6 in the EOF byte.
- Short frame: rows=1, cols=4, 2 pixels then frame_end -> 2 real pixels, 2 zero pads, EOF checksum = XOR of the real bytes.
- Reset mid-frame: rst during the row-1 pixels -> tx_winc=0 the next cycle, busy=0, no EOF. A new frame_start then produces a clean SOF.
- Ignored events: frame_start while busy, and pix_valid while idle -> output stream and drop_count unchanged.
